// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter and the CPU memory stage:
//   - DMEM_ADDR_WIDTH      : word-address width of the single dmem port
//   - DEFAULT_STARVE_LIMIT : default number of denied DMA cycles before a
//                            forced DMA slot
//   - STARVE_CNT_WIDTH     : width of the starvation counter
//   - owner_e              : tag of the requester whose read data returns next
//   - is_read()            : a request with no byte enables is a read
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int DMEM_ADDR_WIDTH      = 14;
  localparam int DEFAULT_STARVE_LIMIT = 8;
  localparam int STARVE_CNT_WIDTH     = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  function automatic logic is_read(input logic [3:0] we);
    return (we == 4'b0000);
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// arb_starve_counter
// Saturating counter of consecutive cycles in which the DMA requester was
// denied. Clear has priority over increment; the count stops at LIMIT.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_clr         : clear the count this edge
//   i_inc         : increment the count this edge (ignored when i_clr)
//   o_at_limit    : count currently equals LIMIT
// -----------------------------------------------------------------------------
module arb_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT_VAL = STARVE_CNT_WIDTH'(LIMIT);
  localparam logic [STARVE_CNT_WIDTH-1:0] CNT_ZERO  = {STARVE_CNT_WIDTH{1'b0}};
  localparam logic [STARVE_CNT_WIDTH-1:0] CNT_ONE   = STARVE_CNT_WIDTH'(1);

  logic [STARVE_CNT_WIDTH-1:0] r_count;

  // Count register: clear, saturating increment, or hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= CNT_ZERO;
    end else if (i_clr) begin
      r_count <= CNT_ZERO;
    end else if (i_inc && (r_count != LIMIT_VAL)) begin
      r_count <= r_count + CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_at_limit = (r_count == LIMIT_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the CPU memory stage and a
// secondary requester (UART loader / DMA). At most one grant per cycle, CPU
// has priority, and a starvation counter forces a DMA slot after STARVE_LIMIT
// consecutive denied cycles. Read data returns one cycle after the grant and
// is steered to the requester that issued the read.
// Ports:
//   i_clk, i_rst                     : clock, synchronous active-high reset
//   i_cpu_req/addr/we/din            : CPU request (single cycle), we==0 is read
//   o_cpu_gnt                        : combinational CPU grant
//   o_cpu_rvalid, o_cpu_rdata        : CPU read return (rdata 0 when not valid)
//   i_dma_* / o_dma_*                : same set for the DMA requester
//   o_mem_en/we/addr/din, i_mem_dout : dmem port (synchronous read)
//   o_starve_active                  : forced DMA grant condition this cycle
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DMEM_ADDR_WIDTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cpu_req,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [3:0]            i_cpu_we,
  input  logic [31:0]           i_cpu_din,
  output logic                  o_cpu_gnt,
  output logic                  o_cpu_rvalid,
  output logic [31:0]           o_cpu_rdata,
  input  logic                  i_dma_req,
  input  logic [ADDR_WIDTH-1:0] i_dma_addr,
  input  logic [3:0]            i_dma_we,
  input  logic [31:0]           i_dma_din,
  output logic                  o_dma_gnt,
  output logic                  o_dma_rvalid,
  output logic [31:0]           o_dma_rdata,
  output logic                  o_mem_en,
  output logic [3:0]            o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_din,
  input  logic [31:0]           i_mem_dout,
  output logic                  o_starve_active
);

  logic   w_at_limit;
  logic   w_force;
  logic   w_cpu_gnt;
  logic   w_dma_gnt;
  logic   w_cnt_clr;
  logic   w_cnt_inc;
  owner_e w_rd_owner_nxt;
  owner_e r_rd_owner;

  // Grant decision; reset suppresses every grant and the forced slot.
  always_comb begin
    w_force   = 1'b0;
    w_dma_gnt = 1'b0;
    w_cpu_gnt = 1'b0;
    if (i_rst) begin
      w_force   = 1'b0;
      w_dma_gnt = 1'b0;
      w_cpu_gnt = 1'b0;
    end else begin
      w_force   = i_dma_req && w_at_limit;
      w_dma_gnt = i_dma_req && (!i_cpu_req || w_force);
      w_cpu_gnt = i_cpu_req && !w_dma_gnt;
    end
  end

  // A DMA that is served or not asking has not been starved.
  assign w_cnt_clr = !i_dma_req || w_dma_gnt;
  assign w_cnt_inc = !w_cnt_clr;

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_cnt_clr),
    .i_inc      (w_cnt_inc),
    .o_at_limit (w_at_limit)
  );

  // Memory port mux: the granted requester drives the port, otherwise all 0.
  always_comb begin
    o_mem_en   = 1'b0;
    o_mem_we   = 4'b0000;
    o_mem_addr = {ADDR_WIDTH{1'b0}};
    o_mem_din  = 32'h0000_0000;
    if (w_cpu_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_we   = i_cpu_we;
      o_mem_addr = i_cpu_addr;
      o_mem_din  = i_cpu_din;
    end else if (w_dma_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_we   = i_dma_we;
      o_mem_addr = i_dma_addr;
      o_mem_din  = i_dma_din;
    end else begin
      o_mem_en   = 1'b0;
      o_mem_we   = 4'b0000;
      o_mem_addr = {ADDR_WIDTH{1'b0}};
      o_mem_din  = 32'h0000_0000;
    end
  end

  // Next read owner: only granted reads produce a return next cycle.
  always_comb begin
    w_rd_owner_nxt = OWN_NONE;
    if (w_cpu_gnt && is_read(i_cpu_we)) begin
      w_rd_owner_nxt = OWN_CPU;
    end else if (w_dma_gnt && is_read(i_dma_we)) begin
      w_rd_owner_nxt = OWN_DMA;
    end else begin
      w_rd_owner_nxt = OWN_NONE;
    end
  end

  // Read owner register; reset drops any in-flight return.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_owner <= OWN_NONE;
    end else begin
      r_rd_owner <= w_rd_owner_nxt;
    end
  end

  assign o_cpu_gnt       = w_cpu_gnt;
  assign o_dma_gnt       = w_dma_gnt;
  assign o_starve_active = w_force;
  assign o_cpu_rvalid    = (r_rd_owner == OWN_CPU);
  assign o_dma_rvalid    = (r_rd_owner == OWN_DMA);
  assign o_cpu_rdata     = o_cpu_rvalid ? i_mem_dout : 32'h0000_0000;
  assign o_dma_rdata     = o_dma_rvalid ? i_mem_dout : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int A     = 14;
  localparam int LIMIT = 3;
  localparam int DEPTH = 16384;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, dma_req;
  logic [A-1:0]  cpu_addr, dma_addr;
  logic [3:0]    cpu_we, dma_we;
  logic [31:0]   cpu_din, dma_din;
  logic          cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
  logic [31:0]   cpu_rdata, dma_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [A-1:0]  mem_addr;
  logic [31:0]   mem_din, mem_dout;
  logic          starve_active;

  int nvec = 0;
  int nerr = 0;

  // bench-side synchronous data memory
  logic [31:0] mem [0:DEPTH-1];

  // reference model state (abstract: denied-streak length, pending return)
  logic [31:0] ref_mem [0:DEPTH-1];
  int          m_streak;
  int          m_own;      // 0 none, 1 cpu, 2 dma
  logic [31:0] m_rdata;

  // expectations for the current cycle
  logic        e_cpu_gnt, e_dma_gnt, e_starve, e_mem_en;
  logic [3:0]  e_mem_we;
  logic [A-1:0] e_mem_addr;
  logic [31:0] e_mem_din;
  logic        e_cpu_rvalid, e_dma_rvalid;
  logic [31:0] e_cpu_rdata, e_dma_rdata;

  dmem_arbiter #(.ADDR_WIDTH(A), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .i_cpu_we(cpu_we), .i_cpu_din(cpu_din),
    .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .i_dma_req(dma_req), .i_dma_addr(dma_addr), .i_dma_we(dma_we), .i_dma_din(dma_din),
    .o_dma_gnt(dma_gnt), .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
    .i_mem_dout(mem_dout), .o_starve_active(starve_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) begin
        mem_dout <= mem[mem_addr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Apply one cycle of inputs at the negedge, compute expectations, advance model.
  task automatic drive(input logic r, input logic cr, input logic [A-1:0] ca,
                       input logic [3:0] cw, input logic [31:0] cd, input logic dr,
                       input logic [A-1:0] da, input logic [3:0] dw, input logic [31:0] dd);
    logic forced;
    @(negedge clk);
    rst = r; cpu_req = cr; cpu_addr = ca; cpu_we = cw; cpu_din = cd;
    dma_req = dr; dma_addr = da; dma_we = dw; dma_din = dd;
    #1;
    e_cpu_rvalid = (m_own == 1);
    e_dma_rvalid = (m_own == 2);
    e_cpu_rdata  = e_cpu_rvalid ? m_rdata : 32'h0;
    e_dma_rdata  = e_dma_rvalid ? m_rdata : 32'h0;
    forced    = !r && dr && (m_streak >= LIMIT);
    e_starve  = forced;
    e_dma_gnt = !r && dr && (!cr || forced);
    e_cpu_gnt = !r && cr && !e_dma_gnt;
    e_mem_en  = e_cpu_gnt || e_dma_gnt;
    e_mem_we  = e_cpu_gnt ? cw : (e_dma_gnt ? dw : 4'b0000);
    e_mem_addr = e_cpu_gnt ? ca : (e_dma_gnt ? da : '0);
    e_mem_din = e_cpu_gnt ? cd : (e_dma_gnt ? dd : 32'h0);
    m_own = 0;
    if (r) begin
      m_streak = 0;
    end else begin
      m_streak = (dr && !e_dma_gnt) ? m_streak + 1 : 0;
      if (e_cpu_gnt) begin
        if (cw == 4'b0000) begin m_own = 1; m_rdata = ref_mem[ca]; end
        else ref_mem[ca] = merge(ref_mem[ca], cd, cw);
      end
      if (e_dma_gnt) begin
        if (dw == 4'b0000) begin m_own = 2; m_rdata = ref_mem[da]; end
        else ref_mem[da] = merge(ref_mem[da], dd, dw);
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b0, '0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 14'h5, 4'h0, 32'h0, 1'b1, 14'h6, 4'h0, 32'h0);
      nvec++; if (cpu_gnt !== 1'b0) begin nerr++; $display("FAIL reset_cpu_gnt got %b want 0", cpu_gnt); end
      nvec++; if (dma_gnt !== 1'b0) begin nerr++; $display("FAIL reset_dma_gnt got %b want 0", dma_gnt); end
      nvec++; if (mem_en !== 1'b0) begin nerr++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
    end
    idle();
    nvec++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0)
      begin nerr++; $display("FAIL reset_rvalid got %b%b want 00", cpu_rvalid, dma_rvalid); end
    nvec++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0)
      begin nerr++; $display("FAIL reset_rdata got %h/%h want 0", cpu_rdata, dma_rdata); end
  endtask

  task automatic test_cpu_read();
    drive(1'b0, 1'b1, 14'h10, 4'h0, 32'h0, 1'b0, '0, 4'h0, 32'h0);
    nvec++; if (cpu_gnt !== 1'b1) begin nerr++; $display("FAIL cpurd_gnt got %b want 1", cpu_gnt); end
    nvec++; if (mem_en !== 1'b1) begin nerr++; $display("FAIL cpurd_mem_en got %b want 1", mem_en); end
    nvec++; if (mem_addr !== 14'h10) begin nerr++; $display("FAIL cpurd_addr got %h want 0010", mem_addr); end
    idle();
    nvec++; if (cpu_rvalid !== 1'b1) begin nerr++; $display("FAIL cpurd_rvalid got %b want 1", cpu_rvalid); end
    nvec++; if (cpu_rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL cpurd_rdata got %h want deadbeef", cpu_rdata); end
    nvec++; if (dma_rvalid !== 1'b0) begin nerr++; $display("FAIL cpurd_dma_rvalid got %b want 0", dma_rvalid); end
  endtask

  task automatic test_dma_write();
    logic [31:0] old;
    old = ref_mem[14'h20];
    drive(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b1, 14'h20, 4'b0011, 32'h12345678);
    nvec++; if (dma_gnt !== 1'b1) begin nerr++; $display("FAIL dmawr_gnt got %b want 1", dma_gnt); end
    nvec++; if (mem_we !== 4'b0011) begin nerr++; $display("FAIL dmawr_mem_we got %b want 0011", mem_we); end
    nvec++; if (mem_din !== 32'h12345678) begin nerr++; $display("FAIL dmawr_mem_din got %h want 12345678", mem_din); end
    idle();
    nvec++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0)
      begin nerr++; $display("FAIL dmawr_no_rvalid got %b%b want 00", cpu_rvalid, dma_rvalid); end
    drive(1'b0, 1'b1, 14'h20, 4'h0, 32'h0, 1'b0, '0, 4'h0, 32'h0);
    idle();
    nvec++; if (cpu_rdata !== {old[31:16], 16'h5678})
      begin nerr++; $display("FAIL dmawr_readback got %h want %h", cpu_rdata, {old[31:16], 16'h5678}); end
  endtask

  // both requesting: expect C for LIMIT cycles, then one D with starve_active
  task automatic both_pattern(input string tag, input int cycles);
    logic want_d;
    for (int i = 0; i < cycles; i++) begin
      drive(1'b0, 1'b1, 14'($urandom_range(0, 31)), 4'h0, 32'h0,
            1'b1, 14'($urandom_range(0, 31)), 4'h0, 32'h0);
      want_d = (((i + 1) % (LIMIT + 1)) == 0);
      nvec++; if (dma_gnt !== want_d || cpu_gnt !== !want_d)
        begin nerr++; $display("FAIL %s_grant cyc%0d got c%b d%b want d%b", tag, i + 1, cpu_gnt, dma_gnt, want_d); end
      nvec++; if (starve_active !== want_d)
        begin nerr++; $display("FAIL %s_starve cyc%0d got %b want %b", tag, i + 1, starve_active, want_d); end
    end
  endtask

  task automatic test_starvation();
    idle();
    both_pattern("starve", 2 * (LIMIT + 1));
  endtask

  task automatic test_interleaved();
    drive(1'b0, 1'b1, 14'h1, 4'h0, 32'h0, 1'b0, '0, 4'h0, 32'h0);
    drive(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b1, 14'h2, 4'h0, 32'h0);
    nvec++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA)
      begin nerr++; $display("FAIL intl_cpu got v%b %h want v1 0000000a", cpu_rvalid, cpu_rdata); end
    nvec++; if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0)
      begin nerr++; $display("FAIL intl_dma_quiet got v%b %h want v0 0", dma_rvalid, dma_rdata); end
    idle();
    nvec++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hB)
      begin nerr++; $display("FAIL intl_dma got v%b %h want v1 0000000b", dma_rvalid, dma_rdata); end
    nvec++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0)
      begin nerr++; $display("FAIL intl_cpu_quiet got v%b %h want v0 0", cpu_rvalid, cpu_rdata); end
  endtask

  task automatic test_reset_mid_read();
    idle();
    both_pattern("prerst", LIMIT - 1);
    drive(1'b1, 1'b1, 14'h10, 4'h0, 32'h0, 1'b1, 14'h11, 4'h0, 32'h0);
    nvec++; if (cpu_gnt !== 1'b0 || mem_en !== 1'b0)
      begin nerr++; $display("FAIL rstmid_gnt got gnt%b en%b want 0 0", cpu_gnt, mem_en); end
    idle();
    nvec++; if (cpu_rvalid !== 1'b0) begin nerr++; $display("FAIL rstmid_rvalid got %b want 0", cpu_rvalid); end
    both_pattern("postrst", LIMIT + 1);
  endtask

  task automatic test_withdrawn();
    idle();
    both_pattern("wd_pre", LIMIT);
    drive(1'b0, 1'b1, 14'h3, 4'h0, 32'h0, 1'b0, 14'h4, 4'h0, 32'h0);
    nvec++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0)
      begin nerr++; $display("FAIL wd_grant got c%b d%b want c1 d0", cpu_gnt, dma_gnt); end
    nvec++; if (starve_active !== 1'b0) begin nerr++; $display("FAIL wd_starve got %b want 0", starve_active); end
    both_pattern("wd_post", LIMIT + 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(1'b0, 1'b1, 14'(i), 4'h0, 32'h0, 1'b0, '0, 4'h0, 32'h0);
      else            drive(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b1, 14'(i), 4'h0, 32'h0);
      if (i > 0) begin
        nvec++; if (cpu_rvalid !== e_cpu_rvalid || dma_rvalid !== e_dma_rvalid)
          begin nerr++; $display("FAIL b2b_tag cyc%0d got %b%b want %b%b", i, cpu_rvalid, dma_rvalid, e_cpu_rvalid, e_dma_rvalid); end
        nvec++; if (cpu_rdata !== e_cpu_rdata || dma_rdata !== e_dma_rdata)
          begin nerr++; $display("FAIL b2b_data cyc%0d got %h/%h want %h/%h", i, cpu_rdata, dma_rdata, e_cpu_rdata, e_dma_rdata); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 99) < 60), 14'($urandom_range(0, 31)),
            ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, 32'($urandom),
            ($urandom_range(0, 99) < 55), 14'($urandom_range(0, 31)),
            ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, 32'($urandom));
      nvec++; if (cpu_gnt !== e_cpu_gnt || dma_gnt !== e_dma_gnt)
        begin nerr++; $display("FAIL rnd_gnt cyc%0d got c%b d%b want c%b d%b", i, cpu_gnt, dma_gnt, e_cpu_gnt, e_dma_gnt); end
      nvec++; if (starve_active !== e_starve)
        begin nerr++; $display("FAIL rnd_starve cyc%0d got %b want %b", i, starve_active, e_starve); end
      nvec++; if (mem_en !== e_mem_en || mem_we !== e_mem_we)
        begin nerr++; $display("FAIL rnd_mem_ctl cyc%0d got en%b we%b want en%b we%b", i, mem_en, mem_we, e_mem_en, e_mem_we); end
      nvec++; if (mem_addr !== e_mem_addr || mem_din !== e_mem_din)
        begin nerr++; $display("FAIL rnd_mem_data cyc%0d got %h/%h want %h/%h", i, mem_addr, mem_din, e_mem_addr, e_mem_din); end
      nvec++; if (cpu_rvalid !== e_cpu_rvalid || cpu_rdata !== e_cpu_rdata)
        begin nerr++; $display("FAIL rnd_cpu_ret cyc%0d got v%b %h want v%b %h", i, cpu_rvalid, cpu_rdata, e_cpu_rvalid, e_cpu_rdata); end
      nvec++; if (dma_rvalid !== e_dma_rvalid || dma_rdata !== e_dma_rdata)
        begin nerr++; $display("FAIL rnd_dma_ret cyc%0d got v%b %h want v%b %h", i, dma_rvalid, dma_rdata, e_dma_rvalid, e_dma_rdata); end
    end
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; cpu_addr = '0; dma_addr = '0;
    cpu_we = 4'h0; dma_we = 4'h0; cpu_din = 32'h0; dma_din = 32'h0;
    m_streak = 0; m_own = 0; m_rdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      mem[i] = w; ref_mem[i] = w;
    end
    mem[14'h10] = 32'hDEADBEEF; ref_mem[14'h10] = 32'hDEADBEEF;
    mem[14'h1]  = 32'hA;        ref_mem[14'h1]  = 32'hA;
    mem[14'h2]  = 32'hB;        ref_mem[14'h2]  = 32'hB;

    test_reset();
    test_cpu_read();
    test_dma_write();
    test_starvation();
    test_interleaved();
    test_reset_mid_read();
    test_withdrawn();
    test_back_to_back();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
